// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the pipeline hazard controller.
//   state_t  : hazard sequencer state encoding (RUN, MEM_WAIT, ERR)
//   REG_ZERO : architectural zero register index; never a real dependency
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the stall/flush sequencer.
//   Pipeline -> controller : id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
//                            mem_branch_taken, dmem_req, dmem_ready
//   Controller -> pipeline : pc_we, ifid_en/flush, idex_en/flush, exmem_en/flush,
//                            memwb_en, mem_err, stall_cnt, wait_cnt, state_dbg
//
// Data-memory handshake: dmem_req is held high by the MEM stage for as long as its
// access is outstanding; the access completes in the cycle where dmem_ready is high
// (req & ready on the same rising edge). While req is high and ready is low the whole
// pipeline is frozen. dmem_ready seen without a pending request in RUN has no effect.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mem_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_we;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] wait_cnt;
    state_t           state_dbg;

    // Pipeline side.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mem_branch_taken, dmem_req, dmem_ready,
        input  pc_we, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, mem_err,
               stall_cnt, wait_cnt, state_dbg
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mem_branch_taken, dmem_req, dmem_ready,
        output pc_we, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, mem_err,
               stall_cnt, wait_cnt, state_dbg
    );

endinterface

// File: rtl/hazard_detect_unit.sv
// Combinational load-use hazard compare.
//   id_rs, id_rt, id_uses_rt : source registers of the instruction in ID
//   ex_mem_read, ex_rt       : load in EX and its destination register
//   load_use                 : ID must wait one cycle for the EX load result
module hazard_detect_unit
    import cpu_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    // A load into $0 writes nothing, so it can never feed a dependent instruction.
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : pipe_hazard_ctrl_if.slave (hazard inputs, register enables/flushes,
//              sticky mem_err, saturating stall/wait counters, state_dbg)
// Priority: ERR > freeze (MEM_WAIT or new miss) > taken branch > load-use > run.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    pipe_hazard_ctrl_if.slave        bus
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [CNT_W-1:0] stall_cnt, wait_cnt;
    logic             load_use;
    logic             stall_inc, wait_inc;

    logic pc_we, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, mem_err;

    hazard_detect_unit u_hdu (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        pc_we       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        mem_err     = 1'b0;
        stall_inc   = 1'b0;
        wait_inc    = 1'b0;

        case (state)
            ST_RUN: begin
                if (bus.dmem_req && !bus.dmem_ready) begin
                    // Miss detected this cycle: freeze now, this cycle counts as timer=1.
                    {pc_we, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    wait_inc  = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                    timer_nxt = TW'(1);
                end else if (bus.mem_branch_taken) begin
                    // The EX load (if any) is squashed too, so load-use is moot.
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, inject one bubble into ID/EX.
                    pc_we      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    // Access completes: the whole pipeline advances this cycle.
                    state_nxt = ST_RUN;
                    timer_nxt = '0;
                end else begin
                    {pc_we, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                    wait_inc = 1'b1;
                    if (timer == TW'(MEM_TIMEOUT)) begin
                        state_nxt = ST_ERR;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
            end
            ST_ERR: begin
                {pc_we, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                mem_err = 1'b1;
            end
            default: begin
                {pc_we, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                state_nxt = ST_RUN;
                timer_nxt = '0;
            end
        endcase

        // Registers hold while reset is asserted, regardless of the RUN defaults.
        if (rst) begin
            {pc_we, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush}         = '0;
            mem_err   = 1'b0;
            stall_inc = 1'b0;
            wait_inc  = 1'b0;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (wait_inc && (wait_cnt != '1))   wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_en    = exmem_en;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_en    = memwb_en;
    assign bus.mem_err     = mem_err;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.wait_cnt    = wait_cnt;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    import cpu_pkg::*;

    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    // m_frozen: consecutive frozen cycles of the outstanding access (0 = none).
    int m_frozen;
    bit m_err;
    int m_stall;
    int m_waitc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_frozen = 0;
        m_err    = 1'b0;
        m_stall  = 0;
        m_waitc  = 0;
    endtask

    task automatic drive(input int rs, input int rt, input bit urt, input bit mr,
                         input int ert, input bit br, input bit req, input bit rdy);
        bus.id_rs            = 5'(rs);
        bus.id_rt            = 5'(rt);
        bus.id_uses_rt       = urt;
        bus.ex_mem_read      = mr;
        bus.ex_rt            = 5'(ert);
        bus.mem_branch_taken = br;
        bus.dmem_req         = req;
        bus.dmem_ready       = rdy;
    endtask

    // Called just after a falling edge with inputs driven: checks this cycle's outputs
    // against the model, advances the model across the next rising edge.
    task automatic step();
        bit lu, frz, waiting;
        logic [7:0] e_en;   // pc, ifid, idex, exmem, memwb
        logic [2:0] e_fl;   // ifid, idex, exmem
        int e_state;
        #1;
        waiting = (m_frozen > 0);
        lu = bus.ex_mem_read && (bus.ex_rt != 0) &&
             ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        frz = !m_err && (waiting || bus.dmem_req) && !bus.dmem_ready;
        e_fl = 3'b000;
        if (m_err || frz)               e_en = 8'b00000;
        else if (waiting)               e_en = 8'b11111;
        else if (bus.mem_branch_taken) begin e_en = 8'b11111; e_fl = 3'b111; end
        else if (lu)                    begin e_en = 8'b00111; e_fl = 3'b010; end
        else                            e_en = 8'b11111;
        e_state = m_err ? 2 : (waiting ? 1 : 0);

        chk("enables", {3'b0, bus.pc_we, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en},
            e_en);
        chk("flushes", {29'b0, bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, {29'b0, e_fl});
        chk("mem_err", bus.mem_err, m_err);
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("wait_cnt", bus.wait_cnt, m_waitc);
        chk("state", bus.state_dbg, e_state);

        if (!m_err) begin
            if (frz) begin
                m_frozen++;
                if (m_waitc < SAT) m_waitc++;
                if (m_frozen == TO + 1) begin
                    m_err    = 1'b1;
                    m_frozen = 0;
                end
            end else if (waiting) begin
                m_frozen = 0;
            end else if (!bus.mem_branch_taken && lu) begin
                if (m_stall < SAT) m_stall++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_enables", {bus.pc_we, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, 0);
        chk("rst_flushes", {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 0);
        chk("rst_mem_err", bus.mem_err, 0);
        chk("rst_counters", {bus.stall_cnt, bus.wait_cnt}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle run, then a reset in the middle of running.
        drive(1, 2, 1, 0, 3, 0, 0, 0); step();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("counters_after_release", {bus.stall_cnt, bus.wait_cnt}, 0);

        // Load-use on rs: one bubble.
        drive(5, 0, 0, 1, 5, 0, 0, 0); step();
        drive(5, 0, 0, 0, 0, 0, 0, 0); step();
        chk("lu_stall_cnt", bus.stall_cnt, 1);

        // Load-use on rt only counts when rt is a source.
        drive(1, 6, 0, 1, 6, 0, 0, 0); step();
        drive(1, 6, 1, 1, 6, 0, 0, 0); step();
        chk("lu_rt_stall_cnt", bus.stall_cnt, 2);

        // Load into $0 is not a hazard.
        drive(0, 0, 1, 1, 0, 0, 0, 0); step();

        // Taken branch overrides load-use.
        drive(5, 0, 0, 1, 5, 1, 0, 0); step();
        chk("br_stall_unchanged", bus.stall_cnt, 2);

        // Miss: 3 frozen cycles then ready.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0); step(); step(); step();
        drive(0, 0, 0, 0, 0, 0, 1, 1); step();
        chk("wait_cnt_3", bus.wait_cnt, 3);
        // Hit with req & ready together in RUN does not freeze.
        drive(0, 0, 0, 0, 0, 0, 1, 1); step();
        chk("hit_wait_cnt", bus.wait_cnt, 3);

        // Timeout: five frozen cycles then ERR, held.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TO + 1; i++) step();
        chk("to_mem_err", bus.mem_err, 1);
        chk("to_wait_cnt", bus.wait_cnt, TO + 1);
        drive(0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step();
        chk("err_held", bus.mem_err, 1);

        // Reset mid-MEM_WAIT with ready pending.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0); step(); step();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1); step();
        chk("rst_wait_state", bus.state_dbg, ST_RUN);

        // Stall counter saturation.
        do_reset();
        drive(7, 0, 0, 1, 7, 0, 0, 0);
        for (int i = 0; i < SAT + 4; i++) step();
        chk("stall_sat", bus.stall_cnt, SAT);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 59) == 0 || (m_err && $urandom_range(0, 3) == 0)) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 7),
                      ($urandom_range(0, 5) == 0),
                      (m_frozen > 0) ? 1'b1 : ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 9) < 4));
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
